mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage initiator for the data memory bus: turns one lb/lbu/lh/lhu/lw/sb/sh/sw per instruction into a req/ack transaction.
//  - Transaction: word-aligned address, byte enables, lane-replicated write data.
//  - Stalls the pipeline until the memory acks; extracts and extends load data; flags misaligned accesses.
//  - Sits between the MEM pipeline register and any variable-latency data memory.
// PARAMETERS
//  TIMEOUT_CYC  64  cycles in REQ without m_ack before the access is abandoned with bus_err (>=1)
// PORTS
//  clk          in   1   clock, all flops on rising edge
//  reset        in   1   asynchronous, active-low; 0 forces reset state immediately
//  op_valid     in   1   MEM stage holds a load/store; op_* held stable while stall=1
//  op_we        in   1   1=store, 0=load
//  op_size      in   2   00 byte, 01 half, 10 word, 11 treated as word
//  op_unsigned  in   1   loads only: 1=zero-extend, 0=sign-extend
//  op_addr      in   32  byte address
//  op_wdata     in   32  store data (low byte/half used for sb/sh)
//  op_pc        in   32  PC of instruction, forwarded for store trace
//  stall        out  1   freeze PC/IF/ID/EX/MEM registers this cycle
//  ld_valid     out  1   ld_data valid (1 cycle, DONE state, loads only)
//  ld_data      out  32  extended load result
//  exc_adel     out  1   misaligned load, combinational while op_valid in IDLE
//  exc_ades     out  1   misaligned store, same rule
//  bus_err      out  1   timeout flag, high for the DONE cycle
//  m_req        out  1   bus request
//  m_we         out  1   bus write
//  m_addr       out  32  {op_addr[31:2],2'b00}
//  m_be         out  4   byte enables, bit i = byte lane i
//  m_wdata      out  32  lane-replicated write data
//  m_pc         out  32  latched op_pc
//  m_ack        in   1   responder completes; sampled only while m_req=1
//  m_rdata      in   32  read word, valid in the m_ack cycle
// BEHAVIOUR
//  Reset: state=IDLE, timeout counter=0, all m_* outputs/regs 0, ld_data=0, stall/ld_valid/bus_err=0.
//  Misaligned: size=01 with addr[0]=1, or size=1x with addr[1:0]!=0.
//   - No request issued; stall=0.
//   - exc_adel (load) or exc_ades (store) = 1 combinationally.
//   - The pipeline owns the trap.
//  FSM IDLE -> REQ -> DONE -> IDLE.
//   IDLE: stall = op_valid & aligned.
//    - On that edge, latch m_addr/m_we/m_be/m_wdata/m_pc, byte offset, size, unsigned; m_req<=1; cnt<=0.
//   REQ: stall=1; m_req and all m_* stable until ack.
//    - m_ack=1 at edge: m_req<=0; ld_data<=extract(m_rdata); -> DONE.
//    - Else cnt++; cnt==TIMEOUT_CYC-1: m_req<=0; bus_err<=1; ld_data<=0; -> DONE.
//   DONE: stall=0; ld_valid = ~we; -> IDLE unconditionally.
//    - The op still visible this cycle is NOT reissued; the pipeline advances at this edge.
//  Latency: aligned access with ack on first REQ cycle = 3 cycles from op_valid to DONE (2 stalled).
//  Byte enables and write data:
//   - byte: be = 4'b0001 << addr[1:0]; wdata = {4{op_wdata[7:0]}}.
//   - half: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{op_wdata[15:0]}}.
//   - word: be = 4'b1111; wdata = op_wdata.
//  Load extract:
//   - byte = m_rdata[8*off +: 8]; half = m_rdata[16*off[1] +: 16].
//   - Extend to 32 by op_unsigned.
//  m_ack while m_req=0 is ignored. Async reset in REQ drops m_req immediately; the transaction is abandoned, not replayed.
// TESTING
//  - lw 0x0000_0010, ack on first REQ cycle, m_rdata=0xDEAD_BEEF -> m_addr=0x10, be=1111; stall 2 cycles; ld_data=0xDEADBEEF.
//  - lb 0x13 m_rdata=0x80AA_BBCC -> ld_data=0xFFFF_FF80; lbu same -> 0x0000_0080; lh 0x12 -> 0xFFFF_80AA.
//  - sb 0x5, wdata 0x1234_5678 -> be=0010, m_wdata=0x7878_7878; sh 0x6 -> be=1100, m_wdata=0x5678_5678.
//  - lh 0x3 / sw 0x2 -> exc_adel / exc_ades=1, m_req never asserted, stall=0.
//  - ack withheld -> m_req drops after TIMEOUT_CYC REQ cycles; DONE with bus_err=1, ld_data=0.
//  - reset=0 mid-REQ (ack delayed 5 cycles) -> m_req=0 same cycle, state IDLE; late m_ack ignored.

Source files
------------

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : MEM-stage initiator for the data memory bus. Converts one
//            lb/lbu/lh/lhu/lw/sb/sh/sw per instruction into a single req/ack
//            transaction, stalls the pipeline until the responder acks (or
//            the access times out), extracts/extends load data and flags
//            misaligned accesses without touching the bus.
// Ports    :
//   clk_i, rst_ni          clock (rising edge), async active-low reset
//   op_valid_i ... op_pc_i MEM-stage operation (held stable while stall_o)
//   stall_o                freeze upstream pipeline registers
//   ld_valid_o, ld_data_o  extended load result, one DONE cycle
//   exc_adel_o/exc_ades_o  misaligned load/store (combinational, IDLE)
//   bus_err_o              access abandoned after TIMEOUT_CYC REQ cycles
//   m_req_o ... m_pc_o     bus request side (all registered)
//   m_ack_i, m_rdata_i     bus response side
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        op_valid_i,
  input  logic        op_we_i,
  input  logic [1:0]  op_size_i,
  input  logic        op_unsigned_i,
  input  logic [31:0] op_addr_i,
  input  logic [31:0] op_wdata_i,
  input  logic [31:0] op_pc_i,
  output logic        stall_o,
  output logic        ld_valid_o,
  output logic [31:0] ld_data_o,
  output logic        exc_adel_o,
  output logic        exc_ades_o,
  output logic        bus_err_o,
  output logic        m_req_o,
  output logic        m_we_o,
  output logic [31:0] m_addr_o,
  output logic [3:0]  m_be_o,
  output logic [31:0] m_wdata_o,
  output logic [31:0] m_pc_o,
  input  logic        m_ack_i,
  input  logic [31:0] m_rdata_i
);

  // Counter only ever holds 0 .. TIMEOUT_CYC-1.
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          m_req_q, m_req_d;
  logic          m_we_q, m_we_d;
  logic [31:0]   m_addr_q, m_addr_d;
  logic [3:0]    m_be_q, m_be_d;
  logic [31:0]   m_wdata_q, m_wdata_d;
  logic [31:0]   m_pc_q, m_pc_d;
  logic [1:0]    off_q, off_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   ld_data_q, ld_data_d;
  logic          bus_err_q, bus_err_d;

  logic          w_misaligned;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_rshift;
  logic [7:0]    w_rbyte;
  logic [15:0]   w_rhalf;
  logic [31:0]   w_extract;

  // Size 2'b11 is handled exactly like a word access.
  assign w_misaligned = (op_size_i == 2'b01) ? op_addr_i[0]
                      : (op_size_i[1] && (op_addr_i[1:0] != 2'b00));

  // Byte enables and lane-replicated store data for the incoming op.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = op_wdata_i;
    case (op_size_i)
      2'b00: begin
        w_be    = 4'b0001 << op_addr_i[1:0];
        w_wdata = {4{op_wdata_i[7:0]}};
      end
      2'b01: begin
        w_be    = op_addr_i[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{op_wdata_i[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = op_wdata_i;
      end
    endcase
  end

  // Load extraction uses the offset/size latched at request time, not the
  // live op inputs.
  assign w_rshift = m_rdata_i >> {off_q, 3'b000};
  assign w_rbyte  = w_rshift[7:0];
  assign w_rhalf  = off_q[1] ? m_rdata_i[31:16] : m_rdata_i[15:0];

  always_comb begin
    w_extract = m_rdata_i;
    case (size_q)
      2'b00:   w_extract = uns_q ? {24'h0, w_rbyte} : {{24{w_rbyte[7]}}, w_rbyte};
      2'b01:   w_extract = uns_q ? {16'h0, w_rhalf} : {{16{w_rhalf[15]}}, w_rhalf};
      default: w_extract = m_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= 32'h0;
      m_be_q    <= 4'h0;
      m_wdata_q <= 32'h0;
      m_pc_q    <= 32'h0;
      off_q     <= 2'b00;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      cnt_q     <= '0;
      ld_data_q <= 32'h0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_be_q    <= m_be_d;
      m_wdata_q <= m_wdata_d;
      m_pc_q    <= m_pc_d;
      off_q     <= off_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      cnt_q     <= cnt_d;
      ld_data_q <= ld_data_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_be_d     = m_be_q;
    m_wdata_d  = m_wdata_q;
    m_pc_d     = m_pc_q;
    off_d      = off_q;
    size_d     = size_q;
    uns_d      = uns_q;
    cnt_d      = cnt_q;
    ld_data_d  = ld_data_q;
    bus_err_d  = bus_err_q;
    stall_o    = 1'b0;
    ld_valid_o = 1'b0;
    exc_adel_o = 1'b0;
    exc_ades_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (op_valid_i) begin
          if (w_misaligned) begin
            // No bus activity; the pipeline takes the trap.
            exc_adel_o = ~op_we_i;
            exc_ades_o = op_we_i;
          end else begin
            stall_o   = 1'b1;
            m_req_d   = 1'b1;
            m_we_d    = op_we_i;
            m_addr_d  = {op_addr_i[31:2], 2'b00};
            m_be_d    = w_be;
            m_wdata_d = w_wdata;
            m_pc_d    = op_pc_i;
            off_d     = op_addr_i[1:0];
            size_d    = op_size_i;
            uns_d     = op_unsigned_i;
            cnt_d     = '0;
            state_d   = S_REQ;
          end
        end
      end

      S_REQ: begin
        stall_o = 1'b1;
        if (m_ack_i) begin
          m_req_d   = 1'b0;
          ld_data_d = w_extract;
          state_d   = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          m_req_d   = 1'b0;
          bus_err_d = 1'b1;
          ld_data_d = 32'h0;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        // Pipeline advances on this edge, so the still-visible op is not
        // picked up again.
        ld_valid_o = ~m_we_q;
        bus_err_d  = 1'b0;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ld_data_o = ld_data_q;
  assign bus_err_o = bus_err_q;
  assign m_req_o   = m_req_q;
  assign m_we_o    = m_we_q;
  assign m_addr_o  = m_addr_q;
  assign m_be_o    = m_be_q;
  assign m_wdata_o = m_wdata_q;
  assign m_pc_o    = m_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Self-checking bench for mem_access_unit. A transaction-level
//            model derives the expected bus fields and load results from
//            address/size arithmetic; a single negedge process compares the
//            DUT against it every cycle, and literal values pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid, op_we, op_unsigned;
  logic [1:0]  op_size;
  logic [31:0] op_addr, op_wdata, op_pc;
  logic        stall, ld_valid, exc_adel, exc_ades, bus_err;
  logic [31:0] ld_data;
  logic        m_req, m_we, m_ack;
  logic [31:0] m_addr, m_wdata, m_pc, m_rdata;
  logic [3:0]  m_be;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYC(TO)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .op_valid_i   (op_valid),
    .op_we_i      (op_we),
    .op_size_i    (op_size),
    .op_unsigned_i(op_unsigned),
    .op_addr_i    (op_addr),
    .op_wdata_i   (op_wdata),
    .op_pc_i      (op_pc),
    .stall_o      (stall),
    .ld_valid_o   (ld_valid),
    .ld_data_o    (ld_data),
    .exc_adel_o   (exc_adel),
    .exc_ades_o   (exc_ades),
    .bus_err_o    (bus_err),
    .m_req_o      (m_req),
    .m_we_o       (m_we),
    .m_addr_o     (m_addr),
    .m_be_o       (m_be),
    .m_wdata_o    (m_wdata),
    .m_pc_o       (m_pc),
    .m_ack_i      (m_ack),
    .m_rdata_i    (m_rdata)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  function automatic bit f_mis(input logic [1:0] sz, input logic [31:0] a);
    int n;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    return (a % n) != 0;
  endfunction

  function automatic logic [3:0] f_be(input logic [1:0] sz, input logic [31:0] a);
    int n;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] f_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'b00) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2'b01) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] f_load(input logic [1:0] sz, input bit uns,
                                         input logic [31:0] a, input logic [31:0] w);
    longint v;
    int nbits;
    nbits = (sz == 2'b00) ? 8 : (sz == 2'b01) ? 16 : 32;
    if (nbits == 32) return w;
    v = (w >> (8 * (a % 4))) & ((64'd1 << nbits) - 1);
    if (!uns && v >= (64'd1 << (nbits - 1))) v = v - (64'd1 << nbits);
    return v[31:0];
  endfunction

  // ---------------- expectations for the compare process ----------------
  bit          chk_en = 1'b0;
  logic        exp_stall, exp_req, exp_ldv, exp_berr, exp_adel, exp_ades, exp_we;
  logic [31:0] exp_addr, exp_wdata, exp_pc, exp_ld;
  logic [3:0]  exp_be;
  int          stall_cnt, req_cnt;
  logic [31:0] cap_ld, cap_wdata, cap_addr;
  logic [3:0]  cap_be;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", {31'h0, stall}, {31'h0, exp_stall});
      chk("m_req", {31'h0, m_req}, {31'h0, exp_req});
      chk("ld_valid", {31'h0, ld_valid}, {31'h0, exp_ldv});
      chk("bus_err", {31'h0, bus_err}, {31'h0, exp_berr});
      chk("exc_adel", {31'h0, exc_adel}, {31'h0, exp_adel});
      chk("exc_ades", {31'h0, exc_ades}, {31'h0, exp_ades});
      if (exp_req) begin
        chk("m_addr", m_addr, exp_addr);
        chk("m_be", {28'h0, m_be}, {28'h0, exp_be});
        chk("m_wdata", m_wdata, exp_wdata);
        chk("m_we", {31'h0, m_we}, {31'h0, exp_we});
        chk("m_pc", m_pc, exp_pc);
      end
      if (exp_ldv || exp_berr) chk("ld_data", ld_data, exp_ld);
      if (stall) stall_cnt++;
      if (m_req) begin
        req_cnt++;
        cap_be    = m_be;
        cap_wdata = m_wdata;
        cap_addr  = m_addr;
      end
      if (ld_valid || bus_err) cap_ld = ld_data;
    end
  end

  task automatic set_idle_exp();
    exp_stall = 0; exp_req = 0; exp_ldv = 0; exp_berr = 0;
    exp_adel = 0; exp_ades = 0;
  endtask

  // ack_dly: REQ cycle index (0-based) on which m_ack is raised; >= TO means never.
  task automatic do_op(input bit we, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] pc, input int ack_dly,
                       input logic [31:0] rdata);
    bit mis, fin, tmo;
    int k;
    stall_cnt = 0; req_cnt = 0;
    cap_ld = 32'h5A5A_5A5A; cap_be = 4'h0; cap_wdata = 32'h0; cap_addr = 32'hFFFF_FFFF;
    op_valid = 1; op_we = we; op_size = sz; op_unsigned = uns;
    op_addr = a; op_wdata = wd; op_pc = pc;
    mis = f_mis(sz, a);
    set_idle_exp();
    exp_adel  = mis & ~we;
    exp_ades  = mis & we;
    exp_stall = ~mis;
    @(posedge clk); #1;
    if (mis) begin
      op_valid = 0;
      set_idle_exp();
      @(posedge clk); #1;
      return;
    end
    set_idle_exp();
    exp_req = 1; exp_stall = 1;
    exp_addr = a & ~32'h3; exp_be = f_be(sz, a); exp_wdata = f_wdata(sz, wd);
    exp_we = we; exp_pc = pc;
    k = 0; fin = 0; tmo = 0;
    while (!fin) begin
      if (k == ack_dly) begin m_ack = 1; m_rdata = rdata; end
      else begin m_ack = 0; m_rdata = $urandom; end
      @(posedge clk); #1;
      if (k == ack_dly) fin = 1;
      else if (k == TO - 1) begin fin = 1; tmo = 1; end
      k++;
    end
    m_ack = 0;
    set_idle_exp();
    exp_ldv  = ~we;
    exp_berr = tmo;
    exp_ld   = tmo ? 32'h0 : f_load(sz, uns, a, rdata);
    @(posedge clk); #1;   // DONE cycle sampled at the preceding negedge
    op_valid = 0;
    set_idle_exp();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 0; op_valid = 0; op_we = 0; op_size = 0; op_unsigned = 0;
    op_addr = 0; op_wdata = 0; op_pc = 0; m_ack = 0; m_rdata = 0;
    set_idle_exp();
    #12;
    chk("rst m_req", {31'h0, m_req}, 32'h0);
    chk("rst m_addr", m_addr, 32'h0);
    chk("rst m_be", {28'h0, m_be}, 32'h0);
    chk("rst m_wdata", m_wdata, 32'h0);
    chk("rst m_pc", m_pc, 32'h0);
    chk("rst ld_data", ld_data, 32'h0);
    chk("rst stall", {29'h0, stall, ld_valid, bus_err}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1;
    chk_en = 1;
    @(posedge clk); #1;

    // lw 0x10, ack on first REQ cycle
    do_op(0, 2'b10, 0, 32'h10, 32'h0, 32'h100, 0, 32'hDEAD_BEEF);
    chk("lw ld_data", cap_ld, 32'hDEAD_BEEF);
    chk("lw stall cycles", stall_cnt, 2);
    chk("lw m_addr", cap_addr, 32'h10);
    chk("lw m_be", {28'h0, cap_be}, 32'hF);

    do_op(0, 2'b00, 0, 32'h13, 32'h0, 32'h104, 0, 32'h80AA_BBCC);
    chk("lb ld_data", cap_ld, 32'hFFFF_FF80);
    do_op(0, 2'b00, 1, 32'h13, 32'h0, 32'h108, 1, 32'h80AA_BBCC);
    chk("lbu ld_data", cap_ld, 32'h0000_0080);
    do_op(0, 2'b01, 0, 32'h12, 32'h0, 32'h10C, 0, 32'h80AA_BBCC);
    chk("lh ld_data", cap_ld, 32'hFFFF_80AA);
    do_op(0, 2'b01, 1, 32'h20, 32'h0, 32'h110, 2, 32'h1234_8001);
    chk("lhu ld_data", cap_ld, 32'h0000_8001);
    do_op(0, 2'b11, 0, 32'h24, 32'h0, 32'h114, 0, 32'hCAFE_F00D);
    chk("size11 ld_data", cap_ld, 32'hCAFE_F00D);

    do_op(1, 2'b00, 0, 32'h5, 32'h1234_5678, 32'h200, 0, 32'h0);
    chk("sb m_be", {28'h0, cap_be}, 32'h2);
    chk("sb m_wdata", cap_wdata, 32'h7878_7878);
    do_op(1, 2'b01, 0, 32'h6, 32'h1234_5678, 32'h204, 3, 32'h0);
    chk("sh m_be", {28'h0, cap_be}, 32'hC);
    chk("sh m_wdata", cap_wdata, 32'h5678_5678);
    do_op(1, 2'b10, 0, 32'h40, 32'hA5A5_0F0F, 32'h208, 0, 32'h0);

    // misaligned accesses: no request at all
    do_op(0, 2'b01, 0, 32'h3, 32'h0, 32'h300, 0, 32'h0);
    chk("lh mis req", req_cnt, 0);
    do_op(1, 2'b10, 0, 32'h2, 32'h0, 32'h304, 0, 32'h0);
    chk("sw mis req", req_cnt, 0);

    // timeout: ack never arrives
    do_op(0, 2'b10, 0, 32'h80, 32'h0, 32'h400, TO + 5, 32'h0);
    chk("tmo req cycles", req_cnt, TO);
    chk("tmo ld_data", cap_ld, 32'h0);

    // async reset in the middle of REQ, ack was due after 5 cycles
    chk_en = 0;
    op_valid = 1; op_we = 0; op_size = 2'b10; op_addr = 32'h50; op_pc = 32'h500;
    @(posedge clk); #1;
    chk("pre-rst m_req", {31'h0, m_req}, 32'h1);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 0; op_valid = 0;
    #1;
    chk("rst mid m_req", {31'h0, m_req}, 32'h0);
    chk("rst mid stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1;
    set_idle_exp();
    chk_en = 1;
    m_ack = 1; m_rdata = 32'h1111_2222;
    repeat (3) begin @(posedge clk); #1; end
    m_ack = 0;
    @(posedge clk); #1;
    chk_en = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
